// File: rtl/clk_ratio_detector.sv
// clk_ratio_detector: measures period and high phase of a divided clock
// sampled in the reference domain; reports lock, mismatch and timeout.
module clk_ratio_detector #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 3,
  parameter int MAX_PERIOD  = 255
) (
  input  logic             I_ref_clk,
  input  logic             I_rst_n,
  input  logic             I_en,
  input  logic             I_div_clk,
  output logic [WIDTH-1:0] O_ratio,
  output logic [WIDTH-1:0] O_high_cnt,
  output logic             O_valid,
  output logic             O_locked,
  output logic             O_mismatch,
  output logic             O_timeout
);

  localparam logic [WIDTH-1:0] MAXP  = WIDTH'(MAX_PERIOD);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [3:0]       LOCKN = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE,
    LOCKED
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;
  logic                   s;
  logic                   rise;
  logic                   fall;
  logic [WIDTH-1:0]       pcnt;
  logic [WIDTH-1:0]       hcnt;
  logic [WIDTH-1:0]       hlat;
  logic [3:0]             match;
  logic [3:0]             match_nx;
  logic                   to_hit;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  assign to_hit   = (pcnt == MAXP) && !rise;
  assign match_nx = (pcnt == O_ratio) ? match + 4'd1 : 4'd1;

  // Synchronizer and edge-detect delay; keeps running while disabled
  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I_div_clk};
      s_d    <= s;
    end
  end

  // Period and high-phase counters, both restart on each rise
  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pcnt <= '0;
      hcnt <= '0;
      hlat <= '0;
    end else if (!I_en || state == IDLE) begin
      pcnt <= '0;
      hcnt <= '0;
      hlat <= '0;
    end else begin
      if (rise) begin
        pcnt <= ONE;
      end else if (pcnt != MAXP) begin
        pcnt <= pcnt + ONE;
      end
      if (rise) begin
        hcnt <= ONE;
      end else if (s && hcnt != MAXP) begin
        hcnt <= hcnt + ONE;
      end
      if (fall) begin
        hlat <= hcnt;
      end
    end
  end

  // Measurement FSM with registered result and status outputs
  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state      <= IDLE;
      match      <= '0;
      O_ratio    <= '0;
      O_high_cnt <= '0;
      O_valid    <= 1'b0;
      O_locked   <= 1'b0;
      O_mismatch <= 1'b0;
      O_timeout  <= 1'b0;
    end else if (!I_en) begin
      state      <= IDLE;
      match      <= '0;
      O_ratio    <= '0;
      O_high_cnt <= '0;
      O_valid    <= 1'b0;
      O_locked   <= 1'b0;
      O_mismatch <= 1'b0;
      O_timeout  <= 1'b0;
    end else begin
      O_valid    <= 1'b0;
      O_mismatch <= 1'b0;
      unique case (state)
        IDLE: begin
          state <= WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (rise) begin
            state     <= MEASURE;
            match     <= '0;
            O_timeout <= 1'b0;
          end else if (to_hit) begin
            match      <= '0;
            O_timeout  <= 1'b1;
            O_locked   <= 1'b0;
            O_ratio    <= '0;
            O_high_cnt <= '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            O_ratio    <= pcnt;
            O_high_cnt <= hlat;
            O_valid    <= 1'b1;
            O_timeout  <= 1'b0;
            match      <= match_nx;
            if (match_nx >= LOCKN) begin
              state    <= LOCKED;
              O_locked <= 1'b1;
            end
          end else if (to_hit) begin
            state      <= WAIT_EDGE;
            match      <= '0;
            O_timeout  <= 1'b1;
            O_locked   <= 1'b0;
            O_ratio    <= '0;
            O_high_cnt <= '0;
          end
        end
        LOCKED: begin
          if (rise) begin
            O_ratio    <= pcnt;
            O_high_cnt <= hlat;
            O_valid    <= 1'b1;
            O_timeout  <= 1'b0;
            if (pcnt != O_ratio) begin
              state      <= MEASURE;
              match      <= 4'd1;
              O_mismatch <= 1'b1;
              O_locked   <= 1'b0;
            end
          end else if (to_hit) begin
            state      <= WAIT_EDGE;
            match      <= '0;
            O_timeout  <= 1'b1;
            O_locked   <= 1'b0;
            O_ratio    <= '0;
            O_high_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_ratio_detector.sv
// tb_clk_ratio_detector: directed divider waveforms, expected results
// queued per output event and checked by an independent monitor.
module tb_clk_ratio_detector;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       div;
  logic [7:0] ratio;
  logic [7:0] high;
  logic       valid;
  logic       locked;
  logic       mism;
  logic       tmo;

  typedef struct {
    bit       is_to;
    int       r;
    int       h;
    bit       l;
    bit       m;
  } exp_t;

  exp_t q[$];
  int   compared;
  int   mismatched;
  logic tmo_q;

  clk_ratio_detector dut (
    .I_ref_clk (clk),
    .I_rst_n   (rst_n),
    .I_en      (en),
    .I_div_clk (div),
    .O_ratio   (ratio),
    .O_high_cnt(high),
    .O_valid   (valid),
    .O_locked  (locked),
    .O_mismatch(mism),
    .O_timeout (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_v(int r, int h, bit l, bit m);
    exp_t e;
    e.is_to = 1'b0;
    e.r = r;
    e.h = h;
    e.l = l;
    e.m = m;
    q.push_back(e);
  endtask

  task automatic push_to();
    exp_t e;
    e.is_to = 1'b1;
    e.r = 0;
    e.h = 0;
    e.l = 1'b0;
    e.m = 1'b0;
    q.push_back(e);
  endtask

  task automatic chk_all0(string tag);
    chk({tag, "_ratio"}, int'(ratio), 0);
    chk({tag, "_high"}, int'(high), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_mismatch"}, int'(mism), 0);
    chk({tag, "_timeout"}, int'(tmo), 0);
  endtask

  task automatic drv(bit v, int n);
    repeat (n) begin
      div = v;
      @(negedge clk);
    end
  endtask

  task automatic period(int r, int h, int n);
    repeat (n) begin
      drv(1'b1, h);
      drv(1'b0, r - h);
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (q.size() != 0 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  // Monitor: pops an expectation on every O_valid pulse or timeout rise
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("valid_kind", 0, int'(e.is_to));
          chk("ratio", int'(ratio), e.r);
          chk("high_cnt", int'(high), e.h);
          chk("locked", int'(locked), int'(e.l));
          chk("mismatch", int'(mism), int'(e.m));
          chk("timeout_at_valid", int'(tmo), 0);
        end
      end
      if (tmo && !tmo_q) begin
        if (q.size() == 0) begin
          chk("unexpected_timeout", 1, 0);
        end else begin
          e = q.pop_front();
          chk("timeout_kind", 1, int'(e.is_to));
          chk("to_ratio", int'(ratio), 0);
          chk("to_high", int'(high), 0);
          chk("to_locked", int'(locked), 0);
        end
      end
      if (mism && !valid) begin
        chk("mismatch_without_valid", 1, 0);
      end
    end
    tmo_q <= tmo;
  end

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    en = 1'b0;
    div = 1'b0;
    compared = 0;
    mismatched = 0;
    tmo_q = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all0("reset");
    rst_n = 1'b1;
    en = 1'b1;
    drv(1'b0, 5);

    // ratio 4: lock on third result
    push_v(4, 2, 0, 0);
    push_v(4, 2, 0, 0);
    push_v(4, 2, 1, 0);
    push_v(4, 2, 1, 0);
    push_v(4, 2, 1, 0);
    period(4, 2, 6);

    // switch to 6 while locked, then relock
    push_v(4, 2, 1, 0);
    push_v(6, 3, 0, 1);
    push_v(6, 3, 0, 0);
    push_v(6, 3, 1, 0);
    period(6, 3, 4);

    // odd ratio 5, then stopped clock
    push_v(6, 3, 1, 0);
    push_v(5, 2, 0, 1);
    push_v(5, 2, 0, 0);
    push_v(5, 2, 1, 0);
    push_to();
    period(5, 2, 4);
    drv(1'b0, 300);
    drain();
    chk("stopped_timeout", int'(tmo), 1);

    // restore ratio 8, then bypass (constant high)
    push_v(8, 4, 0, 0);
    push_v(8, 4, 0, 0);
    push_v(8, 4, 1, 0);
    push_to();
    period(8, 4, 3);
    drv(1'b1, 300);
    drv(1'b0, 10);
    drain();
    chk("bypass_timeout", int'(tmo), 1);

    // long ratios 200 and 255, then back to 4
    push_v(200, 100, 0, 0);
    push_v(200, 100, 0, 0);
    push_v(200, 100, 1, 0);
    push_v(255, 127, 0, 1);
    push_v(255, 127, 0, 0);
    push_v(255, 127, 1, 0);
    push_v(4, 2, 0, 1);
    push_v(4, 2, 0, 0);
    push_v(4, 2, 1, 0);
    push_v(4, 2, 1, 0);
    period(200, 100, 3);
    period(255, 127, 3);
    period(4, 2, 5);
    drv(1'b0, 10);
    drain();
    chk("locked_before_disable", int'(locked), 1);

    // drop enable while locked
    en = 1'b0;
    @(negedge clk);
    chk_all0("disable");
    drv(1'b0, 3);

    // re-enable: first result after two rises
    en = 1'b1;
    push_v(4, 2, 0, 0);
    push_v(4, 2, 0, 0);
    period(4, 2, 3);
    drv(1'b0, 10);

    // one stretched period, then reset mid-measurement
    push_v(14, 2, 0, 0);
    period(4, 2, 1);
    drain();
    rst_n = 1'b0;
    #1;
    chk_all0("reset_mid");
    @(negedge clk);
    drv(1'b0, 2);
    rst_n = 1'b1;
    push_v(4, 2, 0, 0);
    push_v(4, 2, 0, 0);
    period(4, 2, 3);
    drv(1'b0, 10);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
